// File: rtl/pagerank_sched.sv
// pagerank_sched: iteration scheduler for a PageRank datapath.
// Initialises all page values, sweeps update requests across every page,
// tracks the largest per-page change of the sweep and repeats until the
// change falls to eps or the iteration limit is reached.
module pagerank_sched #(
  parameter  int N      = 16,
  parameter  int WIDTH  = 16,
  parameter  int ITER_W = 8,
  localparam int PW     = $clog2(N)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ITER_W-1:0] i_max_iter,
  input  logic [WIDTH-1:0]  i_eps,
  output logic              o_init_req,
  output logic              o_upd_valid,
  output logic [PW-1:0]     o_upd_page,
  input  logic              i_upd_ready,
  input  logic              i_res_valid,
  input  logic [WIDTH-1:0]  i_res_old,
  input  logic [WIDTH-1:0]  i_res_new,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_converged,
  output logic [ITER_W-1:0] o_iter_count
);

  // Result counter needs one extra bit so it can hold the value N.
  localparam int CW = PW + 1;
  localparam logic [PW-1:0]     LAST_PAGE = PW'(N - 1);
  localparam logic [CW-1:0]     N_CNT     = CW'(N);
  localparam logic [ITER_W-1:0] ITER_MAX  = {ITER_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PW-1:0]     r_page;
  logic [CW-1:0]     r_res_cnt;
  logic [WIDTH-1:0]  r_max_delta;
  logic [ITER_W-1:0] r_iter;
  logic              r_conv;
  logic [ITER_W-1:0] r_max_iter;
  logic [WIDTH-1:0]  r_eps;

  logic              w_start_acc;
  logic              w_abort_acc;
  logic              w_hs;
  logic              w_res_count;
  logic [CW-1:0]     w_res_cnt_nxt;
  logic [WIDTH-1:0]  w_delta;
  logic [ITER_W-1:0] w_iter_inc;
  logic              w_conv_now;
  logic              w_last_iter;
  logic              w_restart;

  // Unsigned magnitude of the difference; never wraps.
  function automatic logic [WIDTH-1:0] abs_diff(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] d;
    if (a >= b) begin
      d = a - b;
    end else begin
      d = b - a;
    end
    return d;
  endfunction

  assign w_start_acc = (r_state == S_IDLE) && i_start;
  assign w_abort_acc = i_abort && ((r_state == S_INIT) || (r_state == S_ISSUE) ||
                                   (r_state == S_DRAIN) || (r_state == S_CHECK));
  assign w_hs        = (r_state == S_ISSUE) && i_upd_ready;
  assign w_res_count = i_res_valid && ((r_state == S_ISSUE) || (r_state == S_DRAIN));
  // The counter clamps at N so stray extra strobes cannot overflow it.
  assign w_res_cnt_nxt = (w_res_count && (r_res_cnt != N_CNT)) ? (r_res_cnt + CW'(1)) : r_res_cnt;
  assign w_delta     = abs_diff(i_res_new, i_res_old);
  assign w_iter_inc  = (r_iter == ITER_MAX) ? r_iter : (r_iter + ITER_W'(1));
  assign w_conv_now  = (r_max_delta <= r_eps);
  assign w_last_iter = (({1'b0, r_iter} + (ITER_W + 1)'(1)) == {1'b0, r_max_iter});
  assign w_restart   = (r_state == S_CHECK) && !i_abort && !w_conv_now && !w_last_iter;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; abort takes priority in every abortable state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_INIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_INIT: begin
        if (i_abort) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_abort) begin
          w_state_nxt = S_DONE;
        end else if (w_hs && (r_page == LAST_PAGE)) begin
          if (w_res_cnt_nxt == N_CNT) begin
            w_state_nxt = S_CHECK;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (i_abort) begin
          w_state_nxt = S_DONE;
        end else if (w_res_cnt_nxt == N_CNT) begin
          w_state_nxt = S_CHECK;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_CHECK: begin
        if (i_abort || w_conv_now || w_last_iter) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Moore output decode from the registered state.
  always_comb begin
    o_init_req  = 1'b0;
    o_upd_valid = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE:  o_busy      = 1'b0;
      S_INIT:  o_init_req  = 1'b1;
      S_ISSUE: o_upd_valid = 1'b1;
      S_DRAIN: o_busy      = 1'b1;
      S_CHECK: o_busy      = 1'b1;
      S_DONE:  o_done      = 1'b1;
      default: o_busy      = 1'b0;
    endcase
  end

  assign o_upd_page   = r_page;
  assign o_converged  = r_conv;
  assign o_iter_count = r_iter;

  // Run configuration latched on an accepted start.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_max_iter <= '0;
      r_eps      <= '0;
    end else if (w_start_acc) begin
      r_max_iter <= (i_max_iter == '0) ? ITER_W'(1) : i_max_iter;
      r_eps      <= i_eps;
    end else begin
      r_max_iter <= r_max_iter;
      r_eps      <= r_eps;
    end
  end

  // Page issue pointer; advances on each accepted update request.
  always_ff @(posedge i_clk) begin
    if (i_reset || w_start_acc || w_restart) begin
      r_page <= '0;
    end else if (w_hs) begin
      r_page <= r_page + PW'(1);
    end else begin
      r_page <= r_page;
    end
  end

  // Result counter and running maximum change of the current sweep.
  always_ff @(posedge i_clk) begin
    if (i_reset || w_start_acc || w_restart) begin
      r_res_cnt   <= '0;
      r_max_delta <= '0;
    end else begin
      r_res_cnt <= w_res_cnt_nxt;
      if (w_res_count && (w_delta > r_max_delta)) begin
        r_max_delta <= w_delta;
      end else begin
        r_max_delta <= r_max_delta;
      end
    end
  end

  // Iteration count and convergence flag reported to the host.
  always_ff @(posedge i_clk) begin
    if (i_reset || w_start_acc) begin
      r_iter <= '0;
      r_conv <= 1'b0;
    end else if (w_abort_acc) begin
      r_iter <= r_iter;
      r_conv <= 1'b0;
    end else if (r_state == S_CHECK) begin
      r_iter <= w_iter_inc;
      r_conv <= w_conv_now;
    end else begin
      r_iter <= r_iter;
      r_conv <= r_conv;
    end
  end

endmodule

// File: tb/tb_pagerank_sched.sv
// Self-checking bench for pagerank_sched: a behavioural datapath answers
// update requests with random latency and chosen value changes; the expected
// outcome of each run is derived from the per-sweep maximum change it sent.
module tb_pagerank_sched;

  localparam int N      = 4;
  localparam int WIDTH  = 16;
  localparam int ITER_W = 8;
  localparam int PW     = 2;

  logic              i_clk = 1'b0;
  logic              i_reset, i_start, i_abort, i_upd_ready, i_res_valid;
  logic [ITER_W-1:0] i_max_iter;
  logic [WIDTH-1:0]  i_eps, i_res_old, i_res_new;
  logic              o_init_req, o_upd_valid, o_busy, o_done, o_converged;
  logic [PW-1:0]     o_upd_page;
  logic [ITER_W-1:0] o_iter_count;

  int checks = 0;
  int errors = 0;
  int q_due[$];
  int q_old[$];
  int q_new[$];
  int it_max[0:299];

  always #5 i_clk = ~i_clk;

  pagerank_sched #(.N(N), .WIDTH(WIDTH), .ITER_W(ITER_W)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
    .i_max_iter(i_max_iter), .i_eps(i_eps), .o_init_req(o_init_req),
    .o_upd_valid(o_upd_valid), .o_upd_page(o_upd_page), .i_upd_ready(i_upd_ready),
    .i_res_valid(i_res_valid), .i_res_old(i_res_old), .i_res_new(i_res_new),
    .o_busy(o_busy), .o_done(o_done), .o_converged(o_converged),
    .o_iter_count(o_iter_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_start = 1'b0; i_abort = 1'b0; i_upd_ready = 1'b0; i_res_valid = 1'b0;
    i_res_old = '0; i_res_new = '0;
  endtask

  // One complete run. dmode 0: every page changes by dval; dmode 1: the first
  // big_iters sweeps contain one change above eps, later sweeps stay within eps.
  task automatic do_run(input string tag, input int mi, input int ep, input int dmode,
                        input int dval, input int big_iters, input int ready_mode,
                        input int lat_min, input int lat_max, input int abort_iter,
                        input int reset_iter, input int exp_cycles);
    int mi_eff, hs_total, cyc, budget, init_extra, exp_iter, exp_conv;
    int last_due, due, it, d, old_v, new_v, tmp;
    bit done_seen, stopped, ready, hs, prev_valid, prev_ready, was_reset, was_abort, aborted;
    logic [PW-1:0] prev_page;
    mi_eff = (mi == 0) ? 1 : mi;
    for (int k = 0; k < 300; k++) it_max[k] = 0;
    q_due.delete(); q_old.delete(); q_new.delete();
    idle_inputs();
    i_max_iter = ITER_W'(mi); i_eps = WIDTH'(ep); i_start = 1'b1;
    tick();
    chk({tag, " init_req"}, 32'(o_init_req), 32'd1);
    chk({tag, " busy_init"}, 32'(o_busy), 32'd1);
    chk({tag, " iter_clear"}, 32'(o_iter_count), 32'd0);
    chk({tag, " conv_clear"}, 32'(o_converged), 32'd0);
    budget = 40 * N * (mi_eff + 1) + 50;
    hs_total = 0; cyc = 0; done_seen = 0; stopped = 0; aborted = 0;
    init_extra = 0; last_due = -1; was_abort = 0;
    while (!done_seen && !stopped && cyc < budget) begin
      // Inputs that must be ignored or were latched: scribble them.
      i_start    = 1'($urandom_range(0, 1));
      i_max_iter = ITER_W'($urandom_range(0, 255));
      i_eps      = WIDTH'($urandom_range(0, 65535));
      i_abort    = 1'b0;
      i_reset    = 1'b0;
      case (ready_mode)
        0:       ready = 1'b1;
        1:       ready = (cyc % 2) == 1;
        default: ready = 1'($urandom_range(0, 1));
      endcase
      i_upd_ready = ready;
      if (abort_iter > 0 && !aborted && hs_total == abort_iter * N && !o_upd_valid && o_busy) begin
        i_abort = 1'b1; aborted = 1;
      end
      if (reset_iter > 0 && hs_total == (reset_iter - 1) * N + 2 && o_upd_valid && o_upd_page == PW'(2))
        i_reset = 1'b1;
      if (o_upd_valid) chk({tag, " iter_mid"}, 32'(o_iter_count), 32'(hs_total / N));
      hs = o_upd_valid && ready;
      if (hs) begin
        chk({tag, " page_order"}, 32'(o_upd_page), 32'(hs_total % N));
        it = hs_total / N;
        if (dmode == 0) d = dval;
        else if (it < big_iters && (hs_total % N) == (it % N)) d = $urandom_range(65535, ep + 1);
        else if ((hs_total % N) == 0) d = ep;
        else d = $urandom_range(ep, 0);
        old_v = $urandom_range(65535 - d, 0);
        new_v = old_v + d;
        if ($urandom_range(1, 0) == 1) begin tmp = old_v; old_v = new_v; new_v = tmp; end
        if (d > it_max[it]) it_max[it] = d;
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        q_due.push_back(due); q_old.push_back(old_v); q_new.push_back(new_v);
        hs_total++;
      end
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
        i_res_valid = 1'b1;
        i_res_old = WIDTH'(q_old.pop_front());
        i_res_new = WIDTH'(q_new.pop_front());
        void'(q_due.pop_front());
      end else begin
        i_res_valid = 1'b0;
        i_res_old = WIDTH'($urandom_range(0, 65535));
        i_res_new = WIDTH'($urandom_range(0, 65535));
      end
      prev_valid = o_upd_valid; prev_ready = ready; prev_page = o_upd_page;
      was_reset = i_reset; was_abort = i_abort;
      tick();
      cyc++;
      if (was_reset) begin
        chk({tag, " rst_busy"}, 32'(o_busy), 32'd0);
        chk({tag, " rst_valid"}, 32'(o_upd_valid), 32'd0);
        chk({tag, " rst_iter"}, 32'(o_iter_count), 32'd0);
        chk({tag, " rst_done"}, 32'(o_done), 32'd0);
        chk({tag, " rst_page"}, 32'(o_upd_page), 32'd0);
        chk({tag, " rst_conv"}, 32'(o_converged), 32'd0);
        i_reset = 1'b0;
        idle_inputs();
        tick();
        chk({tag, " rst_no_done"}, 32'(o_done), 32'd0);
        chk({tag, " rst_stays_idle"}, 32'(o_busy), 32'd0);
        stopped = 1;
      end else begin
        if (prev_valid && !prev_ready && o_upd_valid)
          chk({tag, " page_hold"}, 32'(o_upd_page), 32'(prev_page));
        if (o_init_req) init_extra++;
        if (was_abort) chk({tag, " abort_done"}, 32'(o_done), 32'd1);
        if (o_done) done_seen = 1;
      end
    end
    idle_inputs();
    i_reset = 1'b0;
    q_due.delete(); q_old.delete(); q_new.delete();
    if (!stopped) begin
      chk({tag, " done_seen"}, 32'(done_seen), 32'd1);
      chk({tag, " init_once"}, 32'(init_extra), 32'd0);
      if (abort_iter > 0) begin
        exp_conv = 0; exp_iter = abort_iter - 1;
      end else begin
        exp_conv = 0; exp_iter = mi_eff;
        for (int k = 0; k < mi_eff; k++) begin
          if (it_max[k] <= ep) begin exp_conv = 1; exp_iter = k + 1; break; end
        end
        chk({tag, " handshakes"}, 32'(hs_total), 32'(exp_iter * N));
      end
      chk({tag, " converged"}, 32'(o_converged), 32'(exp_conv));
      chk({tag, " iter_count"}, 32'(o_iter_count), 32'(exp_iter));
      chk({tag, " busy_done"}, 32'(o_busy), 32'd1);
      if (exp_cycles >= 0) chk({tag, " latency"}, 32'(cyc), 32'(exp_cycles));
      tick();
      chk({tag, " done_pulse"}, 32'(o_done), 32'd0);
      chk({tag, " idle_busy"}, 32'(o_busy), 32'd0);
      chk({tag, " conv_hold"}, 32'(o_converged), 32'(exp_conv));
      chk({tag, " iter_hold"}, 32'(o_iter_count), 32'(exp_iter));
    end
  endtask

  initial begin
    idle_inputs();
    i_reset = 1'b1; i_max_iter = '0; i_eps = '0;
    tick();
    tick();
    chk("reset init_req", 32'(o_init_req), 32'd0);
    chk("reset upd_valid", 32'(o_upd_valid), 32'd0);
    chk("reset upd_page", 32'(o_upd_page), 32'd0);
    chk("reset busy", 32'(o_busy), 32'd0);
    chk("reset done", 32'(o_done), 32'd0);
    chk("reset converged", 32'(o_converged), 32'd0);
    chk("reset iter_count", 32'(o_iter_count), 32'd0);
    i_reset = 1'b0;
    tick();

    do_run("conv_first", 8, 32'h20, 0, 32'h10, 0, 0, 1, 1, 0, 0, 7);
    do_run("limit3", 3, 32'h20, 0, 32'h100, 0, 0, 1, 1, 0, 0, -1);
    do_run("eps_equal", 4, 32'h40, 0, 32'h40, 0, 0, 1, 2, 0, 0, -1);
    do_run("ready_toggle", 5, 32'h80, 1, 0, 2, 1, 0, 3, 0, 0, -1);
    do_run("abort_drain", 6, 32'h20, 0, 32'h100, 0, 0, 1, 2, 2, 0, -1);
    do_run("after_abort", 4, 32'h100, 1, 0, 1, 2, 0, 3, 0, 0, -1);
    do_run("reset_issue", 5, 32'h20, 0, 32'h100, 0, 0, 1, 1, 0, 2, -1);
    do_run("max_iter0", 0, 32'h20, 0, 32'h100, 0, 2, 0, 2, 0, 0, -1);

    // Abort and stray results while idle must be ignored.
    i_abort = 1'b1; i_res_valid = 1'b1; i_res_old = 16'h0000; i_res_new = 16'hFFFF;
    tick();
    chk("idle_abort busy", 32'(o_busy), 32'd0);
    chk("idle_abort done", 32'(o_done), 32'd0);
    chk("idle_abort conv", 32'(o_converged), 32'd0);
    idle_inputs();
    tick();

    for (int r = 0; r < 6; r++) begin
      do_run("random", $urandom_range(0, 6), $urandom_range(16, 4096), 1, 0,
             $urandom_range(0, 7), 2, 0, 3, 0, 0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
